// File: rtl/banked_mem_resp.sv
// banked_mem_resp: four-bank word memory responder, fixed 2-cycle reads.
// Define BANK_BUSY_MODEL_EN to model per-bank recovery time and stall.
module banked_mem_resp #(
  parameter int MEM_WORDS = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic        rd_valid,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [15:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    bank;
  logic          req;
  logic          acc;
  logic          rd_acc;
  logic          bank_busy;

  logic          v1_q;
  logic          v2_q;
  logic [15:0]   d1_q;
  logic [15:0]   d2_q;

  assign idx  = AW'(32'(addr[15:1]) % MEM_WORDS);
  assign bank = addr[2:1];

  // Illegal: both strobes, or any strobe on an odd byte address.
  assign err = (rd & wr) | ((rd | wr) & addr[0]);
  assign req = rd ^ wr;

  assign stall  = req & ~err & bank_busy;
  assign acc    = req & ~err & ~bank_busy & rst;
  assign rd_acc = acc & rd;

`ifdef BANK_BUSY_MODEL_EN
  logic [1:0] cnt_q [4];
  logic [1:0] cnt_d [4];

  // Target bank reloads to 3 on accept; every other bank counts down.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (acc && bank == 2'(i)) begin
        cnt_d[i] = 2'd3;
      end else if (cnt_q[i] != 2'd0) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  // Bank counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // A bank is busy while its counter is nonzero.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      busy[i] = (cnt_q[i] != 2'd0);
    end
  end

  assign bank_busy = busy[bank];
`else
  assign busy      = 4'b0000;
  assign bank_busy = 1'b0;
`endif

  // Storage array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (acc && wr) begin
      mem[idx] <= data_in;
    end
  end

  // Two-stage read pipe; data captured at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= rd_acc;
      d1_q <= mem[idx];
      v2_q <= v1_q;
      d2_q <= d1_q;
    end
  end

  assign rd_valid = v2_q;
  assign data_out = v2_q ? d2_q : 16'h0000;

endmodule

// File: tb/tb_banked_mem_resp.sv
// tb_banked_mem_resp: scoreboard bench for banked_mem_resp.
// Reference model tracks words, bank accept times and due read cycles.
module tb_banked_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  banked_mem_resp dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ref_mem [32];
  int          last_acc [4];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // A bank is busy for the three cycles after it accepted.
  function automatic bit busy_m(int b);
`ifdef BANK_BUSY_MODEL_EN
    return (cyc - last_acc[b]) <= 3;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input bit r, input bit w, input logic [15:0] a,
                      input logic [15:0] d, output bit stalled);
    bit       e;
    bit       pres;
    bit       st;
    int       b;
    logic [3:0] bz;
    @(posedge clk);
    #1;
    rd = r;
    wr = w;
    addr = a;
    data_in = d;
    #4;
    e = (r && w) || ((r || w) && a[0]);
    pres = r ^ w;
    b = int'(a[2:1]);
    for (int i = 0; i < 4; i++) bz[i] = busy_m(i);
    st = pres && !e && bz[b];
    chk("err", 32'(err), 32'(e));
    chk("stall", 32'(stall), 32'(st));
    chk("busy", 32'(busy), 32'(bz));
    if (pres && !e && !st) begin
      last_acc[b] = cyc;
      if (w) ref_mem[a[5:1]] = d;
      else q.push_back('{cyc + 2, ref_mem[a[5:1]]});
    end
    stalled = st;
  endtask

  task automatic req(input bit r, input bit w, input logic [15:0] a,
                     input logic [15:0] d);
    bit s;
    int n;
    n = 0;
    do begin
      step(r, w, a, d, s);
      n++;
    end while (s && n < 10);
    if (s) begin
      checks++;
      errors++;
      $display("FAIL hold_timeout cyc=%0d got=stalled want=accepted", cyc);
    end
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, s);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) last_acc[i] = -100;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: every cycle, rd_valid must match the due read, if any.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'h1);
        chk("data_out", 32'(data_out), 32'(e.data));
      end else begin
        chk("rd_valid_idle", 32'(rd_valid), 32'h0);
        chk("data_out_idle", 32'(data_out), 32'h0);
      end
    end
  end

  initial begin
    bit          s;
    bit          r;
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
    int          k;

    for (int i = 0; i < 4; i++) last_acc[i] = -100;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;

    #2;
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_rd_valid", 32'(rd_valid), 32'h0);
    chk("init_data_out", 32'(data_out), 32'h0);
    chk("init_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 32; i++) begin
      req(1'b0, 1'b1, 16'(i * 2), 16'($urandom));
    end
    idle(4);

    req(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    idle(3);
    req(1'b1, 1'b0, 16'h0010, 16'h0);
    idle(4);

    req(1'b1, 1'b0, 16'h0000, 16'h0);
    req(1'b1, 1'b0, 16'h0002, 16'h0);
    req(1'b1, 1'b0, 16'h0004, 16'h0);
    req(1'b1, 1'b0, 16'h0006, 16'h0);
    idle(5);

    req(1'b1, 1'b0, 16'h0008, 16'h0);
    req(1'b1, 1'b0, 16'h0000, 16'h0);
    idle(4);

    step(1'b1, 1'b1, 16'h0020, 16'h1234, s);
    step(1'b1, 1'b0, 16'h0021, 16'h0, s);
    step(1'b0, 1'b1, 16'h0023, 16'h5555, s);
    req(1'b1, 1'b0, 16'h0020, 16'h0);
    idle(4);

    for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 16'h0000, 16'h0);
    idle(4);

    req(1'b1, 1'b0, 16'h0004, 16'h0);
    do_reset();
    req(1'b1, 1'b0, 16'h0004, 16'h0);
    idle(4);

    s = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        do_reset();
        s = 1'b0;
      end
      if (!s) begin
        k = $urandom_range(0, 9);
        r = (k < 4) || (k == 9);
        w = (k >= 4 && k < 8) || (k == 9);
        a = 16'($urandom_range(0, 63));
        if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
        d = 16'($urandom);
      end
      step(r, w, a, d, s);
    end
    idle(6);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
